// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad geometry and key code helper
package keypad_pkg;

    localparam int NUM_ROWS   = 4;
    localparam int NUM_COLS   = 4;
    localparam int NUM_KEYS   = NUM_ROWS * NUM_COLS;
    localparam int KEY_CODE_W = $clog2(NUM_KEYS);

    // Linear key index used for key_code and key_state bit positions
    function automatic logic [KEY_CODE_W-1:0] key_code_of(input int row, input int col);
        return KEY_CODE_W'(row * NUM_COLS + col);
    endfunction

endpackage

// File: rtl/keypad_key_filter.sv
// rtl/keypad_key_filter.sv - per-key scan-count debounce filter
module keypad_key_filter #(
    parameter int DEBOUNCE_SCANS = 10
) (
    input  logic hwclk,
    input  logic rst_n,
    input  logic sample,
    input  logic raw,
    input  logic grant,
    output logic state,
    output logic candidate
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             state_q, state_d;

    // A key is ready to commit once it has disagreed for the full window
    assign candidate = sample && (raw != state_q) && (cnt_q == CNT_MAX);
    assign state     = state_q;

    // Count disagreeing scans; a saturated count waits for a grant
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (sample) begin
            if (raw == state_q) begin
                cnt_d = '0;
            end else if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end else if (grant) begin
                state_d = raw;
                cnt_d   = '0;
            end
        end
    end

    // Filter state register
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            state_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with debounced event buffer
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROW_DWELL      = 3000,
    parameter int DEBOUNCE_SCANS = 10
) (
    input  logic                  hwclk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic [NUM_ROWS-1:0]   keypad_row_n,
    input  logic [NUM_COLS-1:0]   keypad_col_n,
    output logic                  key_valid,
    input  logic                  key_ready,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_press,
    output logic [NUM_KEYS-1:0]   key_state
);

    localparam int ROW_W   = $clog2(NUM_ROWS);
    localparam int DWELL_W = $clog2(ROW_DWELL);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(ROW_DWELL - 1);

    logic [NUM_COLS-1:0]   col_meta_q, col_meta_d;
    logic [NUM_COLS-1:0]   col_sync_q, col_sync_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [DWELL_W-1:0]    dwell_q, dwell_d;
    logic                  key_valid_q, key_valid_d;
    logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
    logic                  key_press_q, key_press_d;

    logic                  sample_cycle;
    logic                  buffer_free;
    logic                  commit;
    logic [KEY_CODE_W-1:0] commit_code;
    logic                  commit_raw;
    logic [NUM_KEYS-1:0]   key_sample, key_raw, key_grant, key_cand, key_state_w;

    // The synchronized columns settle two cycles into a row, sampled on its last dwell cycle
    assign sample_cycle = enable && (dwell_q == DWELL_LAST);

    // Rows stay released while held in reset so the row counter's zero value is not driven
    assign keypad_row_n = (rst_n && enable) ? ~(NUM_ROWS'(1) << row_q) : '1;

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_press = key_press_q;
    assign key_state = key_state_w;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        localparam int ROW = k / NUM_COLS;
        localparam int COL = k % NUM_COLS;

        assign key_sample[k] = sample_cycle && (row_q == ROW_W'(ROW));
        assign key_raw[k]    = ~col_sync_q[COL];

        keypad_key_filter #(
            .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
        ) u_filter (
            .hwclk    (hwclk),
            .rst_n    (rst_n),
            .sample   (key_sample[k]),
            .raw      (key_raw[k]),
            .grant    (key_grant[k]),
            .state    (key_state_w[k]),
            .candidate(key_cand[k])
        );
    end

    // Two-flop synchronizer on the asynchronous column lines
    always_comb begin
        col_meta_d = keypad_col_n;
        col_sync_d = col_meta_q;
    end

    // Row/dwell sequencing; the 2-bit row counter wraps mod 4 on its own
    always_comb begin
        row_d   = row_q;
        dwell_d = dwell_q;
        if (!enable) begin
            row_d   = '0;
            dwell_d = '0;
        end else if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            row_d   = row_q + 1'b1;
        end else begin
            dwell_d = dwell_q + 1'b1;
        end
    end

    // Grant one commit per sample, lowest column first, only when the buffer can take it
    always_comb begin
        key_grant   = '0;
        commit      = 1'b0;
        commit_code = '0;
        commit_raw  = 1'b0;
        buffer_free = !key_valid_q || key_ready;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (!commit && buffer_free && key_cand[key_code_of(int'(row_q), c)]) begin
                commit                 = 1'b1;
                commit_code            = key_code_of(int'(row_q), c);
                commit_raw             = key_raw[commit_code];
                key_grant[commit_code] = 1'b1;
            end
        end
    end

    // One-deep event buffer: hold until accepted, reload when a commit lands
    always_comb begin
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        key_press_d = key_press_q;
        if (key_valid_q && key_ready) begin
            key_valid_d = 1'b0;
        end
        if (commit) begin
            key_valid_d = 1'b1;
            key_code_d  = commit_code;
            key_press_d = commit_raw;
        end
    end

    // Scanner state registers
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q  <= '1;
            col_sync_q  <= '1;
            row_q       <= '0;
            dwell_q     <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_press_q <= 1'b0;
        end else begin
            col_meta_q  <= col_meta_d;
            col_sync_q  <= col_sync_d;
            row_q       <= row_d;
            dwell_q     <= dwell_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_press_q <= key_press_d;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
module tb_keypad_scanner;

    localparam int RD = 4;
    localparam int DS = 3;

    logic        hwclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        key_ready = 1'b1;
    logic [3:0]  keypad_row_n;
    logic [3:0]  keypad_col_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_press;
    logic [15:0] key_state;
    logic [15:0] phys = 16'h0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    int last_ev_cyc = 0;
    int valid_seen = 0;

    always #5 hwclk = ~hwclk;

    // Physical matrix: a pressed key pulls its column low while its row is driven
    always_comb begin
        keypad_col_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!keypad_row_n[r] && phys[r*4+c]) keypad_col_n[c] = 1'b0;
    end

    keypad_scanner #(.ROW_DWELL(RD), .DEBOUNCE_SCANS(DS)) dut (
        .hwclk       (hwclk),
        .rst_n       (rst_n),
        .enable      (enable),
        .keypad_row_n(keypad_row_n),
        .keypad_col_n(keypad_col_n),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_code    (key_code),
        .key_press   (key_press),
        .key_state   (key_state)
    );

    // Reference model: time since enable, key press history, counts and an event slot
    int          m_t = 0;
    int          m_cnt [16];
    logic [15:0] m_state = 16'h0;
    logic        m_valid = 1'b0;
    logic [3:0]  m_code = 4'h0;
    logic        m_press = 1'b0;
    logic [15:0] m_h1 = 16'h0;
    logic [15:0] m_h2 = 16'h0;

    always @(posedge hwclk or negedge rst_n) begin : model
        bit free;
        bit done;
        int row;
        int k;
        bit raw;
        if (!rst_n) begin
            m_t = 0;
            for (int i = 0; i < 16; i++) m_cnt[i] = 0;
            m_state = 16'h0;
            m_valid = 1'b0;
            m_code  = 4'h0;
            m_press = 1'b0;
            m_h1    = 16'h0;
            m_h2    = 16'h0;
        end else begin
            free = !m_valid || key_ready;
            if (m_valid && key_ready) m_valid = 1'b0;
            if (enable) begin
                row = (m_t / RD) % 4;
                if (m_t % RD == RD - 1) begin
                    done = 1'b0;
                    for (int c = 0; c < 4; c++) begin
                        k   = row * 4 + c;
                        raw = m_h2[k];
                        if (raw == m_state[k]) m_cnt[k] = 0;
                        else if (m_cnt[k] < DS - 1) m_cnt[k] = m_cnt[k] + 1;
                        else if (free && !done) begin
                            done       = 1'b1;
                            m_state[k] = raw;
                            m_cnt[k]   = 0;
                            m_valid    = 1'b1;
                            m_code     = 4'(k);
                            m_press    = raw;
                        end
                    end
                end
                m_t = m_t + 1;
            end else begin
                m_t = 0;
            end
            m_h2 = m_h1;
            m_h1 = phys;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc_cnt);
        end
    endtask

    always @(posedge hwclk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge hwclk) if (key_valid) valid_seen <= valid_seen + 1;

    // Every-cycle comparison against the model
    always @(negedge hwclk) begin : compare
        logic [3:0] exp_row;
        exp_row = (rst_n && enable) ? ~(4'b0001 << ((m_t / RD) % 4)) : 4'b1111;
        chk("row_n", {12'h0, keypad_row_n}, {12'h0, exp_row});
        chk("key_valid", {15'h0, key_valid}, {15'h0, m_valid});
        chk("key_code", {12'h0, key_code}, {12'h0, m_code});
        chk("key_press", {15'h0, key_press}, {15'h0, m_press});
        chk("key_state", key_state, m_state);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge hwclk);
        #2;
    endtask

    task automatic ev(input string name, input int skip, input logic [3:0] code,
                      input logic press, input logic [15:0] st);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge hwclk);
            if (key_valid && int'(key_code) != skip) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no event within 400 cycles, expected code %0d", name, code);
        end else begin
            last_ev_cyc = cyc_cnt;
            chk({name, "_code"}, {12'h0, key_code}, {12'h0, code});
            chk({name, "_press"}, {15'h0, key_press}, {15'h0, press});
            chk({name, "_state"}, key_state, st);
        end
    endtask

    logic [3:0] row_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    initial begin : stim
        int a;
        int n;
        bit found;
        // Reset, run, reset again mid-scan
        cyc(3);
        rst_n = 1'b1;
        cyc(6);
        rst_n = 1'b0;
        @(negedge hwclk);
        chk("rst_row", {12'h0, keypad_row_n}, 16'h000f);
        chk("rst_valid", {15'h0, key_valid}, 16'h0);
        chk("rst_code", {12'h0, key_code}, 16'h0);
        chk("rst_press", {15'h0, key_press}, 16'h0);
        chk("rst_state", key_state, 16'h0);
        cyc(2);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge hwclk);
            chk("row_seq", {12'h0, keypad_row_n}, {12'h0, row_seq[i/4]});
        end

        // Clean press and release of key 6
        cyc(1);
        phys = 16'h0040;
        ev("s2_press", -1, 4'd6, 1'b1, 16'h0040);
        cyc(1);
        phys = 16'h0;
        ev("s2_release", -1, 4'd6, 1'b0, 16'h0);
        cyc(20);

        // Bounce shorter than the debounce window
        valid_seen = 0;
        phys = 16'h0040; cyc(32);
        phys = 16'h0;    cyc(16);
        phys = 16'h0040; cyc(32);
        phys = 16'h0;    cyc(80);
        chk("s3_no_event", 16'(valid_seen), 16'h0);
        chk("s3_state", key_state, 16'h0);

        // Two keys in one row commit a scan apart, lower column first
        phys = 16'h0900;
        ev("s4_a", -1, 4'd8, 1'b1, 16'h0100);
        a = last_ev_cyc;
        ev("s4_b", -1, 4'd11, 1'b1, 16'h0900);
        chk("s4_gap", 16'(last_ev_cyc - a), 16'd16);
        cyc(1);
        phys = 16'h0;
        ev("s4_rel_a", -1, 4'd8, 1'b0, 16'h0800);
        ev("s4_rel_b", -1, 4'd11, 1'b0, 16'h0);
        cyc(20);

        // Back-pressure: first event held, second deferred and not lost
        key_ready = 1'b0;
        phys = 16'h2002;
        ev("s5_a", -1, 4'd1, 1'b1, 16'h0002);
        cyc(100);
        @(negedge hwclk);
        chk("s5_hold_valid", {15'h0, key_valid}, 16'h1);
        chk("s5_hold_code", {12'h0, key_code}, 16'd1);
        cyc(1);
        key_ready = 1'b1;
        cyc(1);
        key_ready = 1'b0;
        ev("s5_b", 1, 4'd13, 1'b1, 16'h2002);
        cyc(1);
        key_ready = 1'b1;
        phys = 16'h0;
        cyc(120);

        // Disabled scan ignores a held key; re-enable restarts at row 0
        enable = 1'b0;
        phys = 16'h0020;
        valid_seen = 0;
        cyc(80);
        chk("s6_no_event", 16'(valid_seen), 16'h0);
        chk("s6_state", key_state, 16'h0);
        enable = 1'b1;
        n = 0;
        found = 1'b0;
        while (n < 400 && !found) begin
            @(negedge hwclk);
            n++;
            if (key_valid) found = 1'b1;
        end
        chk("s6_latency", 16'(n), 16'd41);
        chk("s6_code", {12'h0, key_code}, 16'd5);
        chk("s6_state", key_state, 16'h0020);
        cyc(1);
        phys = 16'h0;
        cyc(100);

        // Randomized keys, back-pressure and enable drops against the model
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 2) != 0) phys = phys ^ (16'h1 << $urandom_range(0, 15));
            key_ready = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 19) != 0);
            cyc($urandom_range(1, 40));
        end
        enable = 1'b1;
        key_ready = 1'b1;
        phys = 16'h0;
        cyc(300);
        chk("final_state", key_state, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
